// File: rtl/rvj1_lsu_ctrl_pkg.sv
// Shared encodings for the load/store unit: command opcodes, FSM states,
// mcause codes and small decode helpers used by the controller and aligner.
package rvj1_lsu_ctrl_pkg;

    // ctrl[3] = store, ctrl[2] = unsigned load, ctrl[1:0] = access size
    typedef enum logic [3:0] {
        LSU_NO_CMD           = 4'b0000,
        LSU_LOAD_BYTE        = 4'b0001,
        LSU_LOAD_HALF_WORD   = 4'b0010,
        LSU_LOAD_WORD        = 4'b0011,
        LSU_LOAD_BYTE_U      = 4'b0101,
        LSU_LOAD_HALF_WORD_U = 4'b0110,
        LSU_STORE_BYTE       = 4'b1001,
        LSU_STORE_HALF_WORD  = 4'b1010,
        LSU_STORE_WORD       = 4'b1011
    } lsu_ctrl_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2
    } lsu_state_e;

    localparam int LSU_STORE_BIT    = 3;
    localparam int LSU_UNSIGNED_BIT = 2;

    localparam logic [1:0] LSU_SIZE_BYTE = 2'b01;
    localparam logic [1:0] LSU_SIZE_HALF = 2'b10;
    localparam logic [1:0] LSU_SIZE_WORD = 2'b11;

    localparam logic [3:0] CSR_MCAUSE_LOAD_MISALIGNED    = 4'd4;
    localparam logic [3:0] CSR_MCAUSE_LOAD_ACCESS_FAULT  = 4'd5;
    localparam logic [3:0] CSR_MCAUSE_STORE_MISALIGNED   = 4'd6;
    localparam logic [3:0] CSR_MCAUSE_STORE_ACCESS_FAULT = 4'd7;

    function automatic logic lsu_is_op(input logic [3:0] ctrl);
        case (ctrl)
            LSU_LOAD_BYTE, LSU_LOAD_HALF_WORD, LSU_LOAD_WORD,
            LSU_LOAD_BYTE_U, LSU_LOAD_HALF_WORD_U,
            LSU_STORE_BYTE, LSU_STORE_HALF_WORD, LSU_STORE_WORD: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

    function automatic logic lsu_is_known(input logic [3:0] ctrl);
        return lsu_is_op(ctrl) || (ctrl == LSU_NO_CMD);
    endfunction

    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            LSU_SIZE_HALF: return off[0];
            LSU_SIZE_WORD: return off != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lsu_exc_cause(input logic is_store, input logic misaligned);
        if (is_store)
            return misaligned ? CSR_MCAUSE_STORE_MISALIGNED : CSR_MCAUSE_STORE_ACCESS_FAULT;
        return misaligned ? CSR_MCAUSE_LOAD_MISALIGNED : CSR_MCAUSE_LOAD_ACCESS_FAULT;
    endfunction

endpackage

// File: rtl/rvj1_lsu_align.sv
// Byte-lane steering: byte enables and store replication for the bus side,
// lane selection plus sign/zero extension for returning load data.
module rvj1_lsu_align
    import rvj1_lsu_ctrl_pkg::*;
(
    input  logic [3:0]  ctrl_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    always_comb begin
        byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sext     = ~ctrl_i[LSU_UNSIGNED_BIT];
        be_o     = 4'b0000;
        wdata_o  = wdata_i;
        rdata_o  = rdata_i;
        case (ctrl_i[1:0])
            LSU_SIZE_BYTE: begin
                be_o    = 4'b0001 << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sext & byte_sel[7]}}, byte_sel};
            end
            LSU_SIZE_HALF: begin
                be_o    = 4'b0011 << offset_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sext & half_sel[15]}}, half_sel};
            end
            LSU_SIZE_WORD: be_o = 4'b1111;
            default:       be_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/rvj1_lsu_ctrl.sv
// Load/store sequencer: accepts one command at a time and runs it over a
// req/gnt/rvalid bus, reporting completion or an mcause-coded exception.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  LSU_IDLE | ready for a command; misaligned commands fault here
//  LSU_REQ  | data_req_o high, bus fields held from registers until gnt
//  LSU_WAIT | request granted, waiting for rvalid (or timeout)
module rvj1_lsu_ctrl
    import rvj1_lsu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [3:0]  cmd_ctrl_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        exc_o,
    output logic [3:0]  exc_cause_o,
    output logic [31:0] exc_tval_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i
);

    localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    lsu_state_e        state_q, state_d;
    logic [3:0]        ctrl_q, ctrl_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              tmo;
    logic              cmd_mis;
    logic [31:0]       ld_data;

    rvj1_lsu_align u_align (
        .ctrl_i   (ctrl_q),
        .offset_i (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .rdata_i  (data_rdata_i),
        .be_o     (data_be_o),
        .wdata_o  (data_wdata_o),
        .rdata_o  (ld_data)
    );

    // Down-counter reloaded on entering REQ/WAIT; zero means the budget is spent.
    assign tmo         = (TIMEOUT_CYC != 0) && (tmr_q == '0);
    assign cmd_mis     = lsu_misaligned(cmd_ctrl_i[1:0], cmd_addr_i[1:0]);
    assign data_addr_o = {addr_q[31:2], 2'b00};
    assign data_we_o   = ctrl_q[LSU_STORE_BIT];

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tmr_d       = tmr_q;
        cmd_ready_o = 1'b0;
        done_o      = 1'b0;
        rdata_o     = '0;
        exc_o       = 1'b0;
        exc_cause_o = '0;
        exc_tval_o  = '0;
        data_req_o  = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i && lsu_is_op(cmd_ctrl_i)) begin
                    if (cmd_mis) begin
                        exc_o       = 1'b1;
                        exc_cause_o = lsu_exc_cause(cmd_ctrl_i[LSU_STORE_BIT], 1'b1);
                        exc_tval_o  = cmd_addr_i;
                    end else begin
                        ctrl_d  = cmd_ctrl_i;
                        addr_d  = cmd_addr_i;
                        wdata_d = cmd_wdata_i;
                        tmr_d   = TMR_LOAD;
                        state_d = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                if (tmo) begin
                    exc_o       = 1'b1;
                    exc_cause_o = lsu_exc_cause(ctrl_q[LSU_STORE_BIT], 1'b0);
                    exc_tval_o  = addr_q;
                    state_d     = LSU_IDLE;
                end else begin
                    data_req_o = 1'b1;
                    if (data_gnt_i) begin
                        tmr_d   = TMR_LOAD;
                        state_d = LSU_WAIT;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
            end
            LSU_WAIT: begin
                if (data_rvalid_i) begin
                    state_d = LSU_IDLE;
                    if (data_err_i) begin
                        exc_o       = 1'b1;
                        exc_cause_o = lsu_exc_cause(ctrl_q[LSU_STORE_BIT], 1'b0);
                        exc_tval_o  = addr_q;
                    end else begin
                        done_o  = 1'b1;
                        rdata_o = ld_data;
                    end
                end else if (tmo) begin
                    exc_o       = 1'b1;
                    exc_cause_o = lsu_exc_cause(ctrl_q[LSU_STORE_BIT], 1'b0);
                    exc_tval_o  = addr_q;
                    state_d     = LSU_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= LSU_IDLE;
            ctrl_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tmr_q   <= tmr_d;
        end
    end

    a_ctrl_known: assert property (@(posedge clk_i) disable iff (!rstn_i)
        (cmd_valid_i && cmd_ready_o) |-> lsu_is_known(cmd_ctrl_i));

endmodule

// File: tb/tb_rvj1_lsu_ctrl.sv
// Bench for rvj1_lsu_ctrl: directed vector table, randomized transactions
// against a byte-lane reference model, and timeout/reset corner sequences.
module tb_rvj1_lsu_ctrl;
    import rvj1_lsu_ctrl_pkg::*;

    typedef struct packed {
        logic        bus;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
        logic        done;
        logic [31:0] rdata;
        logic        exc;
        logic [3:0]  cause;
        logic [31:0] tval;
    } exp_t;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          gnt_dly;
        int          rv_dly;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        cmd_valid[2], cmd_ready[2], done[2], exc[2], req[2], gnt[2], we[2], rvalid[2], err[2];
    logic [3:0]  cmd_ctrl[2], cause[2], be[2];
    logic [31:0] cmd_addr[2], cmd_wdata[2], rdata[2], tval[2], daddr[2], dwdata[2], drdata[2];

    // Instance 0 never times out; instance 1 uses a 4-cycle budget.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        rvj1_lsu_ctrl #(.TIMEOUT_CYC((g == 0) ? 0 : 4)) u_dut (
            .clk_i(clk), .rstn_i(rstn),
            .cmd_valid_i(cmd_valid[g]), .cmd_ready_o(cmd_ready[g]), .cmd_ctrl_i(cmd_ctrl[g]),
            .cmd_addr_i(cmd_addr[g]), .cmd_wdata_i(cmd_wdata[g]),
            .done_o(done[g]), .rdata_o(rdata[g]), .exc_o(exc[g]), .exc_cause_o(cause[g]),
            .exc_tval_o(tval[g]), .data_req_o(req[g]), .data_gnt_i(gnt[g]),
            .data_addr_o(daddr[g]), .data_we_o(we[g]), .data_be_o(be[g]), .data_wdata_o(dwdata[g]),
            .data_rvalid_i(rvalid[g]), .data_err_i(err[g]), .data_rdata_i(drdata[g])
        );
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic exp_t mkexp(logic bus, logic [3:0] b, logic [31:0] wd, logic w, logic d,
                                   logic [31:0] rd, logic x, logic [3:0] c, logic [31:0] tv);
        exp_t e;
        e = '{bus: bus, be: b, wd: wd, we: w, done: d, rdata: rd, exc: x, cause: c, tval: tv};
        return e;
    endfunction

    function automatic vec_t mkvec(logic [3:0] c, logic [31:0] a, logic [31:0] wd, logic [31:0] rd,
                                   logic er, int gd, int rvd, exp_t e);
        vec_t v;
        v.ctrl = c; v.addr = a; v.wdata = wd; v.rdata = rd; v.err = er;
        v.gnt_dly = gd; v.rv_dly = rvd; v.e = e;
        return v;
    endfunction

    // Reference: access width in bytes, lane = addr mod 4, shift/mask arithmetic.
    function automatic exp_t model(logic [3:0] ctrl, logic [31:0] addr, logic [31:0] wdata,
                                   logic [31:0] rd, logic er);
        exp_t e;
        int nb, off;
        logic st, sg;
        logic [31:0] mask, v;
        e = '0; nb = 0; st = 1'b0; sg = 1'b0;
        case (ctrl)
            LSU_LOAD_BYTE:        begin nb = 1; sg = 1'b1; end
            LSU_LOAD_BYTE_U:      nb = 1;
            LSU_LOAD_HALF_WORD:   begin nb = 2; sg = 1'b1; end
            LSU_LOAD_HALF_WORD_U: nb = 2;
            LSU_LOAD_WORD:        nb = 4;
            LSU_STORE_BYTE:       begin nb = 1; st = 1'b1; end
            LSU_STORE_HALF_WORD:  begin nb = 2; st = 1'b1; end
            LSU_STORE_WORD:       begin nb = 4; st = 1'b1; end
            default:              nb = 0;
        endcase
        if (nb == 0) return e;
        off = int'(addr[1:0]);
        if (off % nb != 0) begin
            e.exc = 1'b1; e.cause = st ? 4'd6 : 4'd4; e.tval = addr;
            return e;
        end
        e.bus = 1'b1;
        e.we  = st;
        e.be  = 4'(((1 << nb) - 1) << off);
        for (int i = 0; i < 4; i++) e.wd[8*i +: 8] = wdata[8*(i % nb) +: 8];
        if (er) begin
            e.exc = 1'b1; e.cause = st ? 4'd7 : 4'd5; e.tval = addr;
        end else begin
            e.done = 1'b1;
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
            v = (rd >> (8 * off)) & mask;
            if (sg && v[8*nb-1]) v = v | ~mask;
            e.rdata = st ? 32'd0 : v;
        end
        return e;
    endfunction

    task automatic run_txn(input int k, input vec_t v, input string tag);
        @(negedge clk);
        cmd_valid[k] = 1'b1; cmd_ctrl[k] = v.ctrl; cmd_addr[k] = v.addr; cmd_wdata[k] = v.wdata;
        #1;
        chk({tag, " accept_ready"}, 32'(cmd_ready[k]), 32'd1);
        chk({tag, " accept_exc"}, 32'(exc[k]), 32'(v.e.exc & ~v.e.bus));
        chk({tag, " accept_req"}, 32'(req[k]), 32'd0);
        if (v.e.exc && !v.e.bus) begin
            chk({tag, " mis_cause"}, 32'(cause[k]), 32'(v.e.cause));
            chk({tag, " mis_tval"}, tval[k], v.e.tval);
        end
        if (!v.e.bus) begin
            @(negedge clk);
            cmd_valid[k] = 1'b0;
            #1;
            chk({tag, " nobus_req"}, 32'(req[k]), 32'd0);
            chk({tag, " nobus_ready"}, 32'(cmd_ready[k]), 32'd1);
            chk({tag, " nobus_pulse"}, 32'({done[k], exc[k]}), 32'd0);
            return;
        end
        for (int c = 0; c <= v.gnt_dly; c++) begin
            @(negedge clk);
            cmd_valid[k] = 1'b0; cmd_ctrl[k] = 4'd0; cmd_addr[k] = $urandom; cmd_wdata[k] = $urandom;
            gnt[k] = (c == v.gnt_dly);
            #1;
            chk({tag, " req"}, 32'(req[k]), 32'd1);
            chk({tag, " addr"}, daddr[k], {v.addr[31:2], 2'b00});
            chk({tag, " be"}, 32'(be[k]), 32'(v.e.be));
            chk({tag, " we"}, 32'(we[k]), 32'(v.e.we));
            if (v.e.we) chk({tag, " wdata"}, dwdata[k], v.e.wd);
            chk({tag, " req_pulse"}, 32'({done[k], exc[k]}), 32'd0);
        end
        for (int c = 0; c <= v.rv_dly; c++) begin
            @(negedge clk);
            gnt[k] = 1'b0;
            rvalid[k] = (c == v.rv_dly);
            err[k] = v.err;
            drdata[k] = (c == v.rv_dly) ? v.rdata : $urandom;
            #1;
            chk({tag, " wait_req"}, 32'(req[k]), 32'd0);
            if (c < v.rv_dly) begin
                chk({tag, " wait_pulse"}, 32'({done[k], exc[k]}), 32'd0);
            end else begin
                chk({tag, " done"}, 32'(done[k]), 32'(v.e.done));
                chk({tag, " exc"}, 32'(exc[k]), 32'(v.e.exc));
                if (v.e.exc) begin
                    chk({tag, " cause"}, 32'(cause[k]), 32'(v.e.cause));
                    chk({tag, " tval"}, tval[k], v.e.tval);
                end
                if (v.e.done && !v.e.we) chk({tag, " rdata"}, rdata[k], v.e.rdata);
            end
        end
        @(negedge clk);
        rvalid[k] = 1'b0; err[k] = 1'b0;
        #1;
        chk({tag, " end_ready"}, 32'(cmd_ready[k]), 32'd1);
        chk({tag, " end_pulse"}, 32'({done[k], exc[k]}), 32'd0);
    endtask

    vec_t tbl[12];
    logic [3:0] ops[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            cmd_valid[k] = 1'b0; cmd_ctrl[k] = 4'd0; cmd_addr[k] = '0; cmd_wdata[k] = '0;
            gnt[k] = 1'b0; rvalid[k] = 1'b0; err[k] = 1'b0; drdata[k] = '0;
        end
        rstn = 1'b0;

        tbl[0]  = mkvec(LSU_LOAD_WORD, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 0,
                        mkexp(1, 4'hF, 32'h0, 0, 1, 32'hDEAD_BEEF, 0, 4'd0, 32'h0));
        tbl[1]  = mkvec(LSU_LOAD_BYTE, 32'h8000_0003, 32'h0, 32'h8012_3456, 1'b0, 0, 0,
                        mkexp(1, 4'b1000, 32'h0, 0, 1, 32'hFFFF_FF80, 0, 4'd0, 32'h0));
        tbl[2]  = mkvec(LSU_LOAD_BYTE_U, 32'h8000_0003, 32'h0, 32'h8012_3456, 1'b0, 0, 0,
                        mkexp(1, 4'b1000, 32'h0, 0, 1, 32'h0000_0080, 0, 4'd0, 32'h0));
        tbl[3]  = mkvec(LSU_STORE_HALF_WORD, 32'h8000_0002, 32'h1234_ABCD, 32'h0, 1'b0, 0, 1,
                        mkexp(1, 4'b1100, 32'hABCD_ABCD, 1, 1, 32'h0, 0, 4'd0, 32'h0));
        tbl[4]  = mkvec(LSU_LOAD_WORD, 32'h8000_0001, 32'h0, 32'h0, 1'b0, 0, 0,
                        mkexp(0, 4'h0, 32'h0, 0, 0, 32'h0, 1, 4'd4, 32'h8000_0001));
        tbl[5]  = mkvec(LSU_STORE_HALF_WORD, 32'h8000_0003, 32'h0, 32'h0, 1'b0, 0, 0,
                        mkexp(0, 4'h0, 32'h0, 0, 0, 32'h0, 1, 4'd6, 32'h8000_0003));
        tbl[6]  = mkvec(LSU_STORE_WORD, 32'h8000_0010, 32'h5566_7788, 32'h0, 1'b1, 5, 0,
                        mkexp(1, 4'hF, 32'h5566_7788, 1, 0, 32'h0, 1, 4'd7, 32'h8000_0010));
        tbl[7]  = mkvec(LSU_LOAD_HALF_WORD, 32'h8000_0102, 32'h0, 32'h9ABC_1234, 1'b0, 1, 2,
                        mkexp(1, 4'b1100, 32'h0, 0, 1, 32'hFFFF_9ABC, 0, 4'd0, 32'h0));
        tbl[8]  = mkvec(LSU_LOAD_HALF_WORD_U, 32'h8000_0102, 32'h0, 32'h9ABC_1234, 1'b0, 0, 0,
                        mkexp(1, 4'b1100, 32'h0, 0, 1, 32'h0000_9ABC, 0, 4'd0, 32'h0));
        tbl[9]  = mkvec(LSU_STORE_BYTE, 32'h8000_0001, 32'h0000_00A5, 32'h0, 1'b0, 0, 0,
                        mkexp(1, 4'b0010, 32'hA5A5_A5A5, 1, 1, 32'h0, 0, 4'd0, 32'h0));
        tbl[10] = mkvec(LSU_LOAD_WORD, 32'h0000_0008, 32'h0, 32'h1111_2222, 1'b1, 0, 0,
                        mkexp(1, 4'hF, 32'h0, 0, 0, 32'h0, 1, 4'd5, 32'h0000_0008));
        tbl[11] = mkvec(LSU_NO_CMD, 32'h0000_0001, 32'h0, 32'h0, 1'b0, 0, 0,
                        mkexp(0, 4'h0, 32'h0, 0, 0, 32'h0, 0, 4'd0, 32'h0));

        ops = '{LSU_NO_CMD, LSU_LOAD_BYTE, LSU_LOAD_BYTE_U, LSU_LOAD_HALF_WORD, LSU_LOAD_HALF_WORD_U,
                LSU_LOAD_WORD, LSU_STORE_BYTE, LSU_STORE_HALF_WORD, LSU_STORE_WORD};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(cmd_ready[0]), 32'd1);
        chk("rst_outs", 32'({done[0], exc[0], req[0], we[0], be[0], cause[0]}), 32'd0);
        chk("rst_rdata", rdata[0], 32'd0);
        chk("rst_tval", tval[0], 32'd0);
        chk("rst_addr", daddr[0], 32'd0);
        chk("rst_wdata", dwdata[0], 32'd0);
        chk("rst_req_to", 32'(req[1]), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 12; i++) run_txn(0, tbl[i], $sformatf("vec%0d", i));

        // Stray gnt/rvalid while idle must be ignored.
        @(negedge clk);
        gnt[0] = 1'b1; rvalid[0] = 1'b1; err[0] = 1'b1;
        #1;
        chk("stray_pulse", 32'({done[0], exc[0]}), 32'd0);
        chk("stray_req", 32'(req[0]), 32'd0);
        @(negedge clk);
        gnt[0] = 1'b0; rvalid[0] = 1'b0; err[0] = 1'b0;
        #1;
        chk("stray_ready", 32'(cmd_ready[0]), 32'd1);

        for (int n = 0; n < 300; n++) begin
            vec_t v;
            v.ctrl    = ops[$urandom_range(0, 8)];
            v.addr    = $urandom;
            v.wdata   = $urandom;
            v.rdata   = $urandom;
            v.err     = ($urandom_range(0, 7) == 0);
            v.gnt_dly = $urandom_range(0, 3);
            v.rv_dly  = $urandom_range(0, 3);
            v.e       = model(v.ctrl, v.addr, v.wdata, v.rdata, v.err);
            run_txn(0, v, $sformatf("rnd%0d", n));
        end

        // Timeout in REQ: fault on the 4th REQ cycle with req already low.
        @(negedge clk);
        cmd_valid[1] = 1'b1; cmd_ctrl[1] = LSU_LOAD_WORD; cmd_addr[1] = 32'h8000_0020;
        #1;
        chk("toreq_accept", 32'(cmd_ready[1]), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            cmd_valid[1] = 1'b0;
            #1;
            if (c < 4) begin
                chk($sformatf("toreq_req%0d", c), 32'(req[1]), 32'd1);
                chk($sformatf("toreq_noexc%0d", c), 32'(exc[1]), 32'd0);
            end else begin
                chk("toreq_exc", 32'(exc[1]), 32'd1);
                chk("toreq_cause", 32'(cause[1]), 32'd5);
                chk("toreq_tval", tval[1], 32'h8000_0020);
                chk("toreq_reqlow", 32'(req[1]), 32'd0);
            end
        end
        @(negedge clk);
        #1;
        chk("toreq_ready", 32'(cmd_ready[1]), 32'd1);
        chk("toreq_after", 32'({done[1], exc[1], req[1]}), 32'd0);

        // Timeout in WAIT on a store; a late rvalid afterwards is ignored.
        @(negedge clk);
        cmd_valid[1] = 1'b1; cmd_ctrl[1] = LSU_STORE_WORD; cmd_addr[1] = 32'h8000_0024;
        @(negedge clk);
        cmd_valid[1] = 1'b0; gnt[1] = 1'b1;
        #1;
        chk("towait_req", 32'(req[1]), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            gnt[1] = 1'b0;
            #1;
            if (c < 4) chk($sformatf("towait_noexc%0d", c), 32'(exc[1]), 32'd0);
            else begin
                chk("towait_exc", 32'(exc[1]), 32'd1);
                chk("towait_cause", 32'(cause[1]), 32'd7);
            end
        end
        @(negedge clk);
        rvalid[1] = 1'b1;
        #1;
        chk("late_rvalid_pulse", 32'({done[1], exc[1]}), 32'd0);
        chk("late_rvalid_ready", 32'(cmd_ready[1]), 32'd1);
        @(negedge clk);
        rvalid[1] = 1'b0;

        // Reset during REQ drops req immediately.
        @(negedge clk);
        cmd_valid[0] = 1'b1; cmd_ctrl[0] = LSU_LOAD_WORD; cmd_addr[0] = 32'h0000_0040;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        #1;
        chk("rstreq_req", 32'(req[0]), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rstreq_reqlow", 32'(req[0]), 32'd0);
        chk("rstreq_ready", 32'(cmd_ready[0]), 32'd1);
        @(negedge clk);
        rstn = 1'b1;

        // Reset during WAIT, then a stray rvalid gives no pulse.
        @(negedge clk);
        cmd_valid[0] = 1'b1; cmd_ctrl[0] = LSU_LOAD_WORD; cmd_addr[0] = 32'h0000_0044;
        @(negedge clk);
        cmd_valid[0] = 1'b0; gnt[0] = 1'b1;
        @(negedge clk);
        gnt[0] = 1'b0;
        #1;
        chk("rstwait_ready_pre", 32'(cmd_ready[0]), 32'd0);
        rstn = 1'b0;
        #1;
        chk("rstwait_ready", 32'(cmd_ready[0]), 32'd1);
        chk("rstwait_outs", 32'({done[0], exc[0], req[0]}), 32'd0);
        @(negedge clk);
        rstn = 1'b1; rvalid[0] = 1'b1; drdata[0] = 32'h1234_5678;
        #1;
        chk("rstwait_stray", 32'({done[0], exc[0]}), 32'd0);
        chk("rstwait_ready2", 32'(cmd_ready[0]), 32'd1);
        @(negedge clk);
        rvalid[0] = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
